mult_req_sequencer: RTL

// - Handshake front/back end for the 32x32 signed sequential multiplier: accepts one operand

---
 rtl/mult_req_sequencer_pkg.sv | 16 +
 rtl/mult_req_sequencer_if.sv | 39 +++
 rtl/mult_timeout_counter.sv | 25 ++
 rtl/mult_req_sequencer.sv | 89 ++++++++
 4 files changed

// File: rtl/mult_req_sequencer_pkg.sv
// Shared definitions for the multiplier request sequencer: default sizes and
// the sequencer FSM state encoding.
package mult_req_sequencer_pkg;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_TIMEOUT = 200;
  localparam int MULT_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mult_req_sequencer_if.sv
// Handshake bundle around the sequencer: upstream operand channel, multiplier
// launch/result channel and downstream product channel. Names keep the
// direction as seen by the sequencer itself.
interface mult_req_sequencer_if
  import mult_req_sequencer_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  // upstream operands
  logic               i_valid;
  logic               o_ready;
  logic [WIDTH-1:0]   i_a;
  logic [WIDTH-1:0]   i_b;
  // multiplier side
  logic               o_mul_start;
  logic [WIDTH-1:0]   o_mul_a;
  logic [WIDTH-1:0]   o_mul_b;
  logic               i_mul_done;
  logic [2*WIDTH-1:0] i_mul_product;
  // downstream product
  logic               o_valid;
  logic               i_ready;
  logic [2*WIDTH-1:0] o_product;
  logic               o_error;

  // sequencer view
  modport slave (
    input  i_valid, i_a, i_b, i_mul_done, i_mul_product, i_ready,
    output o_ready, o_mul_start, o_mul_a, o_mul_b, o_valid, o_product, o_error
  );

  // environment view (upstream source, multiplier, downstream sink)
  modport master (
    output i_valid, i_a, i_b, i_mul_done, i_mul_product, i_ready,
    input  o_ready, o_mul_start, o_mul_a, o_mul_b, o_valid, o_product, o_error
  );

endinterface

// File: rtl/mult_timeout_counter.sv
// Watchdog counter for the multiplier wait: cleared on launch, counts while
// enabled, flags expiry when it sits on TIMEOUT-1.
module mult_timeout_counter #(
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] cnt;

  // clear has priority so a fresh launch always starts counting from zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      cnt <= '0;
    else if (i_clr) cnt <= '0;
    else if (i_en)  cnt <= cnt + 1'b1;
  end

  assign o_expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mult_req_sequencer.sv
// Valid/ready front/back end for the sequential multiplier: captures one
// operand pair, fires a single start pulse, waits (with watchdog) for done
// and holds the product until downstream takes it. One op in flight at most.
module mult_req_sequencer
  import mult_req_sequencer_pkg::*;
#(
  parameter int WIDTH   = MULT_WIDTH,
  parameter int TIMEOUT = MULT_TIMEOUT,
  parameter int CNT_W   = MULT_CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mult_req_sequencer_if.slave  bus
);

  seq_state_e state;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;

  // watchdog is zeroed during the launch cycle and runs only while waiting
  assign wd_clr = (state == ST_START);
  assign wd_en  = (state == ST_WAIT);

  mult_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wd (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (wd_clr),
    .i_en      (wd_en),
    .o_expired (wd_expired)
  );

  // sequencer FSM with all handshake outputs registered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      bus.o_ready     <= 1'b1;
      bus.o_mul_start <= 1'b0;
      bus.o_mul_a     <= '0;
      bus.o_mul_b     <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_product   <= '0;
      bus.o_error     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_valid && bus.o_ready) begin
            bus.o_mul_a     <= bus.i_a;
            bus.o_mul_b     <= bus.i_b;
            bus.o_ready     <= 1'b0;
            bus.o_mul_start <= 1'b1;
            state           <= ST_START;
          end
        end
        // start is high for exactly this cycle; a done seen now is stale
        ST_START: begin
          bus.o_mul_start <= 1'b0;
          state           <= ST_WAIT;
        end
        // done takes priority over a watchdog expiry in the same cycle
        ST_WAIT: begin
          if (bus.i_mul_done) begin
            bus.o_product <= bus.i_mul_product;
            bus.o_error   <= 1'b0;
            bus.o_valid   <= 1'b1;
            state         <= ST_HOLD;
          end else if (wd_expired) begin
            bus.o_product <= '0;
            bus.o_error   <= 1'b1;
            bus.o_valid   <= 1'b1;
            state         <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
            bus.o_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
